// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the 5-stage MIPS core.
package pipe_pkg;

  // Decoded control bundle produced by the Control unit.
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

  // A bubble: no register write, no memory access, no control transfer.
  localparam ctrl_t CTRL_NOP = '{
    reg_dst:    1'b0,
    alu_src:    1'b0,
    mem_to_reg: 1'b0,
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    branch:     1'b0,
    jump:       1'b0,
    alu_op:     2'b00
  };

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection: flags an ID instruction that reads the register
// an in-flight EX load is about to write. Purely combinational so the
// forwarding unit can reuse it.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic              id_reg_dst,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic [5:0]        id_funct,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              haz
);

  logic is_shift_s;
  logic uses_rs_s;
  logic uses_rt_s;
  logic rs_hit_s;
  logic rt_hit_s;

  // Decide which source fields the ID instruction really reads, then match them.
  always_comb begin
    is_shift_s = 1'b0;
    case (id_funct)
      FUNCT_SLL, FUNCT_SRL: is_shift_s = 1'b1;  // rs field holds no source register
      default:              is_shift_s = 1'b0;
    endcase

    uses_rs_s = !id_jump && !(id_reg_dst && is_shift_s);
    uses_rt_s = id_reg_dst || id_mem_write || id_branch;

    rs_hit_s  = uses_rs_s && (ex_rt == id_rs);
    rt_hit_s  = uses_rt_s && (ex_rt == id_rt);

    // $0 is hard-wired zero, so a load into it never creates a dependency.
    haz = ex_valid && ex_mem_read && (ex_rt != {REG_AW{1'b0}}) &&
          id_valid && (rs_hit_s || rt_hit_s);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX flush,
// global hold and a saturating bubble counter.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  ctrl_t             id_ctrl_i,
  input  logic [5:0]        id_funct_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [DATA_W-1:0] id_pc4_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output ctrl_t             ex_ctrl_o,
  output logic [5:0]        ex_funct_o,
  output logic [REG_AW-1:0] ex_rs_o,
  output logic [REG_AW-1:0] ex_rt_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [DATA_W-1:0] ex_pc4_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic haz_s;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_load_use_detect (
    .ex_valid     (ex_valid_o),
    .ex_mem_read  (ex_ctrl_o.mem_read),
    .ex_rt        (ex_rt_o),
    .id_valid     (id_valid_i),
    .id_reg_dst   (id_ctrl_i.reg_dst),
    .id_mem_write (id_ctrl_i.mem_write),
    .id_branch    (id_ctrl_i.branch),
    .id_jump      (id_ctrl_i.jump),
    .id_funct     (id_funct_i),
    .id_rs        (id_rs_i),
    .id_rt        (id_rt_i),
    .haz          (haz_s)
  );

  // Front-end stall: a flush discards the ID instruction anyway, and a hold
  // already freezes the front end, so neither needs a separate stall.
  always_comb begin
    stall_o = haz_s && !flush_i && !hold_i;
  end

  // Pipeline register: hold > flush > load-use bubble > normal capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_o   <= 1'b0;
      ex_ctrl_o    <= CTRL_NOP;
      ex_funct_o   <= 6'd0;
      ex_rs_o      <= {REG_AW{1'b0}};
      ex_rt_o      <= {REG_AW{1'b0}};
      ex_rd_o      <= {REG_AW{1'b0}};
      ex_rs_data_o <= {DATA_W{1'b0}};
      ex_rt_data_o <= {DATA_W{1'b0}};
      ex_imm_o     <= {DATA_W{1'b0}};
      ex_pc4_o     <= {DATA_W{1'b0}};
      bubble_cnt_o <= {CNT_W{1'b0}};
    end else if (hold_i) begin
      ex_valid_o   <= ex_valid_o;
      bubble_cnt_o <= bubble_cnt_o;
    end else if (flush_i || haz_s) begin
      ex_valid_o   <= 1'b0;
      ex_ctrl_o    <= CTRL_NOP;
      ex_funct_o   <= 6'd0;
      ex_rs_o      <= {REG_AW{1'b0}};
      ex_rt_o      <= {REG_AW{1'b0}};
      ex_rd_o      <= {REG_AW{1'b0}};
      ex_rs_data_o <= {DATA_W{1'b0}};
      ex_rt_data_o <= {DATA_W{1'b0}};
      ex_imm_o     <= {DATA_W{1'b0}};
      ex_pc4_o     <= {DATA_W{1'b0}};
      // Only load-use bubbles are performance events; flushes are not counted.
      if (!flush_i && (bubble_cnt_o != CNT_MAX)) begin
        bubble_cnt_o <= bubble_cnt_o + CNT_ONE;
      end else begin
        bubble_cnt_o <= bubble_cnt_o;
      end
    end else begin
      ex_valid_o   <= id_valid_i;
      ex_ctrl_o    <= id_valid_i ? id_ctrl_i : CTRL_NOP;
      ex_funct_o   <= id_funct_i;
      ex_rs_o      <= id_rs_i;
      ex_rt_o      <= id_rt_i;
      ex_rd_o      <= id_rd_i;
      ex_rs_data_o <= id_rs_data_i;
      ex_rt_data_o <= id_rt_data_i;
      ex_imm_o     <= id_imm_i;
      ex_pc4_o     <= id_pc4_i;
      bubble_cnt_o <= bubble_cnt_o;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected stall and EX
// state into queues, two monitor processes pop and compare.
module tb_id_ex_stage;
  import pipe_pkg::*;

  localparam int DW      = 32;
  localparam int AW      = 5;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic          valid;
    ctrl_t         ctrl;
    logic [5:0]    funct;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc4;
    logic [CW-1:0] cnt;
  } ex_t;

  localparam ctrl_t C_LW = '{reg_dst:1'b0, alu_src:1'b1, mem_to_reg:1'b1, reg_write:1'b1,
                             mem_read:1'b1, mem_write:1'b0, branch:1'b0, jump:1'b0,
                             alu_op:ALUOP_MEM};
  localparam ctrl_t C_R  = '{reg_dst:1'b1, alu_src:1'b0, mem_to_reg:1'b0, reg_write:1'b1,
                             mem_read:1'b0, mem_write:1'b0, branch:1'b0, jump:1'b0,
                             alu_op:ALUOP_RTYPE};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hold_i, flush_i, id_valid_i;
  ctrl_t         id_ctrl_i;
  logic [5:0]    id_funct_i;
  logic [AW-1:0] id_rs_i, id_rt_i, id_rd_i;
  logic [DW-1:0] id_rs_data_i, id_rt_data_i, id_imm_i, id_pc4_i;
  logic          stall_o, ex_valid_o;
  ctrl_t         ex_ctrl_o;
  logic [5:0]    ex_funct_o;
  logic [AW-1:0] ex_rs_o, ex_rt_o, ex_rd_o;
  logic [DW-1:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_pc4_o;
  logic [CW-1:0] bubble_cnt_o;

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i), .id_funct_i(id_funct_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
    .id_imm_i(id_imm_i), .id_pc4_i(id_pc4_i),
    .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_ctrl_o(ex_ctrl_o),
    .ex_funct_o(ex_funct_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
    .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o),
    .ex_imm_o(ex_imm_o), .ex_pc4_o(ex_pc4_o), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk = ~clk;

  ex_t  m;             // reference view of what EX holds
  ex_t  state_q[$];
  logic stall_q[$];
  logic last_stall;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic ex_t dut_state();
    ex_t a;
    a = {ex_valid_o, ex_ctrl_o, ex_funct_o, ex_rs_o, ex_rt_o, ex_rd_o,
         ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_pc4_o, bubble_cnt_o};
    return a;
  endfunction

  // Present one ID slot on the falling edge and predict the stage's reaction.
  task automatic drive(input logic h, input logic f, input logic v, input ctrl_t c,
                       input logic [5:0] fn, input logic [AW-1:0] rs,
                       input logic [AW-1:0] rt, input logic [AW-1:0] rd, input bit push);
    logic reads_rs, reads_rt, dep, haz;
    ex_t  nx;
    @(negedge clk);
    hold_i = h; flush_i = f; id_valid_i = v; id_ctrl_i = c; id_funct_i = fn;
    id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
    id_rs_data_i = $urandom(); id_rt_data_i = $urandom();
    id_imm_i = $urandom(); id_pc4_i = $urandom();
    // Jumps read nothing; sll/srl R-types read only rt; rt is a source for
    // R-types, stores and branches.
    reads_rs = !c.jump && !(c.reg_dst && (fn == 6'h00 || fn == 6'h02));
    reads_rt = c.reg_dst || c.mem_write || c.branch;
    dep = (reads_rs && rs == m.rt) || (reads_rt && rt == m.rt);
    haz = m.valid && m.ctrl.mem_read && (m.rt != 0) && v && dep;
    last_stall = haz && !f && !h;
    nx = m;
    if (h) begin
      nx = m;
    end else if (f || haz) begin
      nx = '0;
      nx.cnt = m.cnt;
      if (!f && int'(m.cnt) < CNT_MAX) nx.cnt = m.cnt + 1'b1;
    end else begin
      nx = '{valid: v, ctrl: (v ? c : CTRL_NOP), funct: fn, rs: rs, rt: rt, rd: rd,
             rs_data: id_rs_data_i, rt_data: id_rt_data_i, imm: id_imm_i,
             pc4: id_pc4_i, cnt: m.cnt};
    end
    if (push) begin
      stall_q.push_back(last_stall);
      state_q.push_back(nx);
      m = nx;
    end
  endtask

  task automatic lw8();
    drive(1'b0, 1'b0, 1'b1, C_LW, 6'h2b, 5'd1, 5'd8, 5'd0, 1'b1);
  endtask

  task automatic add_dep(input logic h, input logic f);
    drive(h, f, 1'b1, C_R, 6'h20, 5'd8, 5'd10, 5'd9, 1'b1);
  endtask

  // Stall monitor: combinational output sampled mid-cycle.
  initial begin
    logic e;
    forever begin
      @(negedge clk);
      #2;
      if (stall_q.size() > 0) begin
        e = stall_q.pop_front();
        chk("stall", 200'(stall_o), 200'(e));
      end
    end
  end

  // EX state monitor: registered outputs sampled just after the rising edge.
  initial begin
    ex_t e;
    forever begin
      @(posedge clk);
      #1;
      if (state_q.size() > 0) begin
        e = state_q.pop_front();
        chk("ex_state", 200'(dut_state()), 200'(e));
      end
    end
  end

  initial begin
    logic [9:0] r;
    ctrl_t      c;
    logic [AW-1:0] pick[4];
    rst_n = 1'b0; hold_i = 1'b0; flush_i = 1'b0; id_valid_i = 1'b0; id_ctrl_i = CTRL_NOP;
    id_funct_i = 6'd0; id_rs_i = '0; id_rt_i = '0; id_rd_i = '0;
    id_rs_data_i = '0; id_rt_data_i = '0; id_imm_i = '0; id_pc4_i = '0;
    m = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_state", 200'(dut_state()), 200'(0));
    chk("reset_stall", 200'(stall_o), 200'(0));
    rst_n = 1'b1;

    // Load-use: one bubble, then the add is captured with rs=8.
    lw8(); add_dep(1'b0, 1'b0); add_dep(1'b0, 1'b0);
    // Load into $0 never stalls.
    drive(1'b0, 1'b0, 1'b1, C_LW, 6'h00, 5'd1, 5'd0, 5'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, C_R, 6'h20, 5'd0, 5'd0, 5'd9, 1'b1);
    // sll reads only rt, so rs field 8 is no dependency.
    lw8(); drive(1'b0, 1'b0, 1'b1, C_R, 6'h00, 5'd8, 5'd3, 5'd9, 1'b1);
    // Flush beats hazard.
    lw8(); add_dep(1'b0, 1'b1);
    // Hold beats hazard for three cycles, then normal flow resumes.
    lw8(); add_dep(1'b1, 1'b0); add_dep(1'b1, 1'b0); add_dep(1'b1, 1'b0);
    add_dep(1'b0, 1'b0); add_dep(1'b0, 1'b0);

    // Reset mid-stall: outputs clear at once and the stall drops.
    lw8();
    drive(1'b0, 1'b0, 1'b1, C_R, 6'h20, 5'd8, 5'd10, 5'd9, 1'b0);
    #1;
    chk("stall_before_reset", 200'(stall_o), 200'(last_stall));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_state", 200'(dut_state()), 200'(0));
    chk("async_reset_stall", 200'(stall_o), 200'(0));
    m = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Saturation: 17 load-use pairs against a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      lw8(); add_dep(1'b0, 1'b0); add_dep(1'b0, 1'b0);
    end
    @(posedge clk);
    #2;
    chk("sat_cnt", 200'(bubble_cnt_o), 200'(CNT_MAX));

    // Random traffic biased towards register collisions.
    for (int i = 0; i < 400; i++) begin
      r = 10'($urandom());
      c = r;
      c.mem_read = ($urandom_range(0, 2) == 0);
      pick[0] = 5'd0; pick[1] = 5'd8; pick[2] = 5'd9; pick[3] = 5'($urandom());
      drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 6) != 0), c,
            (($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom())),
            pick[$urandom_range(0, 3)], pick[$urandom_range(0, 3)],
            5'($urandom()), 1'b1);
    end

    @(posedge clk);
    #3;
    chk("queues_drained", 200'(state_q.size() + stall_q.size()), 200'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
